// File: rtl/dds_nco_axis.sv
// dds_nco_axis: small NCO/DDS core with an AXI-Stream style config input.
// A phase accumulator drives a quarter-wave sine LUT through a 3-stage
// pipeline, producing one signed sample every clock.
// The LUT contents are computed at elaboration from the same formula that
// generates sin_qw.hex, so no external memory image is needed.
// Optional feature: define DDS_PHASE_OUT_EN to enable the m_axis_phase_* output.
// Without it, the phase registers are removed and the phase outputs are tied to 0.
module dds_nco_axis #(
  parameter int PHASE_W = 28,
  parameter int OUT_W   = 8,
  parameter int LUT_AW  = 6
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    s_axis_config_tvalid,
  output logic                    s_axis_config_tready,
  input  logic [31:0]             s_axis_config_tdata,
  output logic                    m_axis_data_tvalid,
  output logic signed [OUT_W-1:0] m_axis_data_tdata,
  output logic                    m_axis_phase_tvalid,
  output logic [31:0]             m_axis_phase_tdata
);

  localparam int LUT_N = 1 << LUT_AW;
  localparam int MAG_W = OUT_W - 1;
  localparam int LUT_W = LUT_N * MAG_W;

  // Fixed-point Taylor series in Q30. The accuracy is far finer than half an
  // output LSB, so rounding matches a double-precision sin().
  function automatic logic [LUT_W-1:0] build_lut();
    logic [LUT_W-1:0] bits;
    longint one_q, pi_q, amp, x, x2, term, sum, v;
    bits  = '0;
    one_q = 64'sd1 << 30;
    pi_q  = 64'sd3373259426;
    amp   = (64'sd1 << (OUT_W - 1)) - 64'sd1;
    for (int e = 0; e < LUT_N; e++) begin
      x    = (longint'(2 * e + 1) * pi_q) / longint'(4 * LUT_N);
      x2   = (x * x) / one_q;
      term = x;
      sum  = x;
      for (int k = 1; k <= 10; k++) begin
        term = -((term * x2) / one_q) / longint'((2 * k) * (2 * k + 1));
        sum  = sum + term;
      end
      v = (amp * sum + one_q / 2) / one_q;
      bits[e*MAG_W +: MAG_W] = MAG_W'(v);
    end
    return bits;
  endfunction

  localparam logic [LUT_W-1:0] LUT_BITS = build_lut();

  logic [PHASE_W-1:0]      acc;
  logic [PHASE_W-1:0]      pinc;
  logic                    ready;
  logic                    accept;
  logic                    resync;
  logic                    s1_valid;
  logic [1:0]              s1_q;
  logic [LUT_AW-1:0]       s1_i;
  logic [LUT_AW-1:0]       lut_idx;
  logic                    s2_valid;
  logic [MAG_W-1:0]        s2_mag;
  logic                    s2_neg;
  logic signed [OUT_W-1:0] mag_ext;
  logic                    data_valid;
  logic signed [OUT_W-1:0] data;
  logic [MAG_W-1:0]        lut_rom [LUT_N];
  logic                    unused_cfg;

  assign accept     = ready & s_axis_config_tvalid;
  assign resync     = s_axis_config_tdata[31];
  assign lut_idx    = s1_q[0] ? ~s1_i : s1_i;
  assign mag_ext    = {1'b0, s2_mag};
  assign unused_cfg = &{1'b0, s_axis_config_tdata};

  // Unpack the elaboration-time table into a ROM array.
  always_comb begin
    for (int e = 0; e < LUT_N; e++) begin
      lut_rom[e] = LUT_BITS[e*MAG_W +: MAG_W];
    end
  end

  // Config handshake and phase accumulator. A RESYNC word zeroes the
  // accumulator; a new increment takes effect on the following edge.
  always_ff @(posedge clk) begin
    if (!rst) begin
      ready <= 1'b0;
      pinc  <= '0;
      acc   <= '0;
    end else begin
      ready <= 1'b1;
      if (accept) begin
        pinc <= s_axis_config_tdata[PHASE_W-1:0];
      end
      if (accept && resync) begin
        acc <= '0;
      end else begin
        acc <= acc + pinc;
      end
    end
  end

  // Sine pipeline: quadrant split, mirrored LUT lookup, then sign application.
  always_ff @(posedge clk) begin
    if (!rst) begin
      s1_valid   <= 1'b0;
      s1_q       <= '0;
      s1_i       <= '0;
      s2_valid   <= 1'b0;
      s2_mag     <= '0;
      s2_neg     <= 1'b0;
      data_valid <= 1'b0;
      data       <= '0;
    end else begin
      s1_valid   <= 1'b1;
      s1_q       <= acc[PHASE_W-1 -: 2];
      s1_i       <= acc[PHASE_W-3 -: LUT_AW];
      s2_valid   <= s1_valid;
      s2_mag     <= lut_rom[lut_idx];
      s2_neg     <= s1_q[1];
      data_valid <= s2_valid;
      data       <= s2_valid ? (s2_neg ? -mag_ext : mag_ext) : '0;
    end
  end

  assign s_axis_config_tready = ready;
  assign m_axis_data_tvalid   = data_valid;
  assign m_axis_data_tdata    = data;

`ifdef DDS_PHASE_OUT_EN
  logic [PHASE_W-1:0] phase_d1;
  logic [PHASE_W-1:0] phase_d2;
  logic [PHASE_W-1:0] phase_out;

  // Phase delay line, kept aligned with the sine pipeline.
  always_ff @(posedge clk) begin
    if (!rst) begin
      phase_d1  <= '0;
      phase_d2  <= '0;
      phase_out <= '0;
    end else begin
      phase_d1  <= acc;
      phase_d2  <= phase_d1;
      phase_out <= phase_d2;
    end
  end

  assign m_axis_phase_tvalid = data_valid;
  assign m_axis_phase_tdata  = {{(32-PHASE_W){1'b0}}, phase_out};
`else
  assign m_axis_phase_tvalid = 1'b0;
  assign m_axis_phase_tdata  = '0;
`endif

endmodule

// File: tb/tb_dds_nco_axis.sv
// tb_dds_nco_axis: self-checking bench for dds_nco_axis.
// Combines a table of reset/start-up vectors, hand-written sweep, wrap and
// resync sequences, and random config traffic checked against a sine model.
module tb_dds_nco_axis;

  localparam int PHASE_W = 28;
  localparam int OUT_W   = 8;
  localparam int LUT_AW  = 6;
  localparam int unsigned MASK = 32'h0FFF_FFFF;
  localparam real PI = 3.14159265358979323846;

  typedef struct {
    bit          rst;
    bit          cv;
    logic [31:0] cd;
    bit          exp_ready;
    bit          exp_valid;
    int          exp_data;
    int unsigned exp_phase;
  } vec_t;

  logic                    clk = 1'b0;
  logic                    rst = 1'b0;
  logic                    cfg_valid = 1'b0;
  logic [31:0]             cfg_data = '0;
  logic                    cfg_ready;
  logic                    data_valid;
  logic signed [OUT_W-1:0] data;
  logic                    phase_valid;
  logic [31:0]             phase;

  int checks = 0;
  int errors = 0;

  int unsigned m_acc;
  int unsigned m_pinc;
  int unsigned m_hist [3];
  bit          m_ready;
  int          m_since;

  vec_t vecs [14];
  int   sweep [101];

  dds_nco_axis #(.PHASE_W(PHASE_W), .OUT_W(OUT_W), .LUT_AW(LUT_AW)) dut (
    .clk                  (clk),
    .rst                  (rst),
    .s_axis_config_tvalid (cfg_valid),
    .s_axis_config_tready (cfg_ready),
    .s_axis_config_tdata  (cfg_data),
    .m_axis_data_tvalid   (data_valid),
    .m_axis_data_tdata    (data),
    .m_axis_phase_tvalid  (phase_valid),
    .m_axis_phase_tdata   (phase)
  );

  always #5 clk = ~clk;

  // Ideal sine at the centre of the phase bin: a full-wave view of the quarter-wave table.
  function automatic int sample_of(int unsigned ph);
    int unsigned addr;
    real theta;
    real v;
    addr  = ph >> (PHASE_W - LUT_AW - 2);
    theta = 2.0 * PI * (real'(addr) + 0.5) / real'(1 << (LUT_AW + 2));
    v     = 127.0 * $sin(theta);
    return (v >= 0.0) ? $rtoi(v + 0.5) : -$rtoi(0.5 - v);
  endfunction

  task automatic check(input string name, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic model_edge(input bit r, input bit cv, input logic [31:0] cd);
    bit accept;
    if (!r) begin
      m_acc   = 0;
      m_pinc  = 0;
      m_ready = 0;
      m_since = 0;
      m_hist  = '{0, 0, 0};
    end else begin
      accept    = m_ready && cv;
      m_hist[2] = m_hist[1];
      m_hist[1] = m_hist[0];
      m_hist[0] = m_acc;
      if (m_since < 1000) m_since++;
      m_acc = (accept && cd[31]) ? 0 : ((m_acc + m_pinc) & MASK);
      if (accept) m_pinc = cd & MASK;
      m_ready = 1;
    end
  endtask

  task automatic drive_cycle(input bit r, input bit cv, input logic [31:0] cd);
    rst       = r;
    cfg_valid = cv;
    cfg_data  = cd;
    @(posedge clk);
    model_edge(r, cv, cd);
    @(negedge clk);
  endtask

  task automatic check_output();
    bit v;
    v = (m_since >= 3);
    check("tready", cfg_ready, m_ready);
    check("data_tvalid", data_valid, v);
    check("data_tdata", data, v ? sample_of(m_hist[2]) : 0);
`ifdef DDS_PHASE_OUT_EN
    check("phase_tvalid", phase_valid, v);
    check("phase_tdata", phase, v ? m_hist[2] : 0);
`else
    check("phase_tvalid", phase_valid, 0);
    check("phase_tdata", phase, 0);
`endif
  endtask

  task automatic apply_stimulus(input bit r, input bit cv, input logic [31:0] cd);
    drive_cycle(r, cv, cd);
    check_output();
  endtask

  task automatic check_table(input int i);
    check($sformatf("vec%0d_ready", i), cfg_ready, vecs[i].exp_ready);
    check($sformatf("vec%0d_valid", i), data_valid, vecs[i].exp_valid);
    check($sformatf("vec%0d_data", i), data, vecs[i].exp_data);
`ifdef DDS_PHASE_OUT_EN
    check($sformatf("vec%0d_phase", i), phase, vecs[i].exp_phase);
    check($sformatf("vec%0d_pvalid", i), phase_valid, vecs[i].exp_valid);
`else
    check($sformatf("vec%0d_phase", i), phase, 0);
`endif
  endtask

  task automatic run_table();
    for (int i = 0; i < 14; i++) begin
      drive_cycle(vecs[i].rst, vecs[i].cv, vecs[i].cd);
      check_table(i);
    end
  endtask

  initial begin
    int pos_cnt;
    int neg_cnt;
    int peak;
    logic [31:0] cd;

    // Reset, start-up latency, then pinc = 2^27 alternating +LUT[0] / -LUT[0].
    for (int i = 0; i < 4; i++) vecs[i] = '{1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 0, 0};
    vecs[4]  = '{1'b1, 1'b0, 32'h0,         1'b1, 1'b0,  0, 0};
    vecs[5]  = '{1'b1, 1'b0, 32'h0,         1'b1, 1'b0,  0, 0};
    vecs[6]  = '{1'b1, 1'b0, 32'h0,         1'b1, 1'b1,  2, 0};
    vecs[7]  = '{1'b1, 1'b1, 32'h0800_0000, 1'b1, 1'b1,  2, 0};
    vecs[8]  = '{1'b1, 1'b0, 32'h0,         1'b1, 1'b1,  2, 0};
    vecs[9]  = '{1'b1, 1'b0, 32'h0,         1'b1, 1'b1,  2, 0};
    vecs[10] = '{1'b1, 1'b0, 32'h0,         1'b1, 1'b1,  2, 0};
    vecs[11] = '{1'b1, 1'b0, 32'h0,         1'b1, 1'b1, -2, 32'h0800_0000};
    vecs[12] = '{1'b1, 1'b0, 32'h0,         1'b1, 1'b1,  2, 0};
    vecs[13] = '{1'b1, 1'b0, 32'h0,         1'b1, 1'b1, -2, 32'h0800_0000};

    model_edge(1'b0, 1'b0, 32'h0);
    run_table();

    // 1 MHz sweep from a resync: half-period sign split and full-scale peak.
    apply_stimulus(1'b1, 1'b1, {1'b1, 3'b000, 28'd2684354});
    for (int j = 1; j <= 103; j++) begin
      apply_stimulus(1'b1, 1'b0, 32'h0);
      if (j >= 3) sweep[j-3] = int'(data);
    end
    pos_cnt = 0;
    neg_cnt = 0;
    peak    = 0;
    for (int n = 0; n <= 100; n++) begin
      if (n < 50 && sweep[n] >= 0) pos_cnt++;
      if (n > 50 && sweep[n] < 0) neg_cnt++;
      if (sweep[n] > peak) peak = sweep[n];
      if (-sweep[n] > peak) peak = -sweep[n];
    end
    check("sweep_pos_half", pos_cnt, 50);
    check("sweep_neg_half", neg_cnt, 50);
    check("sweep_peak", peak, 127);

    // pinc = 2^28-1: phase counts down and wraps 0 -> 0xFFFFFFF.
    apply_stimulus(1'b1, 1'b1, {1'b1, 3'b000, 28'hFFF_FFFF});
    for (int j = 1; j <= 8; j++) begin
      apply_stimulus(1'b1, 1'b0, 32'h0);
`ifdef DDS_PHASE_OUT_EN
      if (j == 3) check("wrap_zero", phase, 0);
      if (j == 4) check("wrap_top", phase, 32'h0FFF_FFFF);
`endif
    end

    // Mid-run resync while sweeping.
    apply_stimulus(1'b1, 1'b1, {4'b0000, 28'd2684354});
    for (int j = 0; j < 20; j++) apply_stimulus(1'b1, 1'b0, 32'h0);
    apply_stimulus(1'b1, 1'b1, {1'b1, 3'b000, 28'd2684354});
    for (int j = 1; j <= 5; j++) begin
      apply_stimulus(1'b1, 1'b0, 32'h0);
      check("resync_tvalid", data_valid, 1);
`ifdef DDS_PHASE_OUT_EN
      if (j == 3) check("resync_zero", phase, 0);
      if (j == 4) check("resync_step", phase, 2684354);
`endif
    end

    // Mid-sweep reset: the restart must look exactly like the first start-up.
    run_table();

    // Random config traffic with occasional resets.
    for (int j = 0; j < 400; j++) begin
      cd     = $urandom;
      cd[31] = ($urandom_range(0, 3) == 0);
      apply_stimulus(($urandom_range(0, 99) != 0), ($urandom_range(0, 7) == 0), cd);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
